// File: rtl/alu_rs_gen_if.sv
// Dispatch, common-data-bus and issue signals of the ALU reservation station.
// The station itself takes the slave view; the dispatcher/ALU side takes master.
interface alu_rs_gen_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4,
    parameter int ADDR_W = 32,
    parameter int OP_W   = 6,
    parameter int CDB_N  = 2
);
    logic                    disp_valid_in;
    logic                    disp_ready_out;
    logic [DATA_W-1:0]       disp_a_in;
    logic [TAG_W-1:0]        disp_qj_in;
    logic [TAG_W-1:0]        disp_qk_in;
    logic [DATA_W-1:0]       disp_vj_in;
    logic [DATA_W-1:0]       disp_vk_in;
    logic [TAG_W-1:0]        disp_dest_in;
    logic [ADDR_W-1:0]       disp_pc_in;
    logic [OP_W-1:0]         disp_opcode_in;
    logic                    disp_use_k_in;
    logic [CDB_N-1:0]        cdb_valid_in;
    logic [CDB_N*TAG_W-1:0]  cdb_tag_in;
    logic [CDB_N*DATA_W-1:0] cdb_data_in;
    logic                    issue_valid_out;
    logic                    issue_ready_in;
    logic [DATA_W-1:0]       issue_a_out;
    logic [DATA_W-1:0]       issue_vj_out;
    logic [DATA_W-1:0]       issue_vk_out;
    logic [TAG_W-1:0]        issue_dest_out;
    logic [ADDR_W-1:0]       issue_pc_out;
    logic [OP_W-1:0]         issue_opcode_out;

    modport master (
        output disp_valid_in, disp_a_in, disp_qj_in, disp_qk_in, disp_vj_in, disp_vk_in,
               disp_dest_in, disp_pc_in, disp_opcode_in, disp_use_k_in,
               cdb_valid_in, cdb_tag_in, cdb_data_in, issue_ready_in,
        input  disp_ready_out, issue_valid_out, issue_a_out, issue_vj_out, issue_vk_out,
               issue_dest_out, issue_pc_out, issue_opcode_out
    );

    modport slave (
        input  disp_valid_in, disp_a_in, disp_qj_in, disp_qk_in, disp_vj_in, disp_vk_in,
               disp_dest_in, disp_pc_in, disp_opcode_in, disp_use_k_in,
               cdb_valid_in, cdb_tag_in, cdb_data_in, issue_ready_in,
        output disp_ready_out, issue_valid_out, issue_a_out, issue_vj_out, issue_vk_out,
               issue_dest_out, issue_pc_out, issue_opcode_out
    );
endinterface

// File: rtl/alu_rs_gen.sv
// ALU reservation station: DEPTH entries with CDB operand capture, age-matrix
// oldest-ready select and a back-pressure tolerant issue register.
module alu_rs_gen #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4,
    parameter int ADDR_W = 32,
    parameter int OP_W   = 6,
    parameter int CDB_N  = 2
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic                       rdy_in,
    input  logic                       flush_in,
    alu_rs_gen_if.slave                rs,
    output logic [$clog2(DEPTH+1)-1:0] count_out
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  older [DEPTH];
    logic [DATA_W-1:0] e_a    [DEPTH];
    logic [TAG_W-1:0]  e_qj   [DEPTH];
    logic [DATA_W-1:0] e_vj   [DEPTH];
    logic [TAG_W-1:0]  e_qk   [DEPTH];
    logic [DATA_W-1:0] e_vk   [DEPTH];
    logic [TAG_W-1:0]  e_dest [DEPTH];
    logic [ADDR_W-1:0] e_pc   [DEPTH];
    logic [OP_W-1:0]   e_op   [DEPTH];

    logic              iss_vld_p1;
    logic [DATA_W-1:0] iss_a_p1, iss_vj_p1, iss_vk_p1;
    logic [TAG_W-1:0]  iss_dest_p1;
    logic [ADDR_W-1:0] iss_pc_p1;
    logic [OP_W-1:0]   iss_op_p1;

    logic [CNT_W-1:0]  cnt;
    logic              disp_rdy, disp_fire, iss_load, win_vld, blocked;
    logic [IDX_W-1:0]  free_idx, win_idx;
    logic [DEPTH-1:0]  cand;
    logic [DATA_W:0]   wk_j [DEPTH];
    logic [DATA_W:0]   wk_k [DEPTH];
    logic [DATA_W:0]   dj_hit, dk_hit;
    logic [TAG_W-1:0]  disp_qk_eff;

    // Returns {hit, data}; the reverse scan lets the lowest matching port win.
    function automatic logic [DATA_W:0] cdb_lookup(
        input logic [TAG_W-1:0]        tag,
        input logic [CDB_N-1:0]        vld,
        input logic [CDB_N*TAG_W-1:0]  tags,
        input logic [CDB_N*DATA_W-1:0] data
    );
        logic [DATA_W:0] r;
        r = '0;
        for (int p = CDB_N-1; p >= 0; p--) begin
            if (vld[p] && (tag != '0) && (tags[p*TAG_W +: TAG_W] == tag))
                r = {1'b1, data[p*DATA_W +: DATA_W]};
        end
        return r;
    endfunction

    always_comb begin
        cnt      = '0;
        free_idx = '0;
        for (int i = 0; i < DEPTH; i++)
            cnt = cnt + CNT_W'(busy[i]);
        for (int i = DEPTH-1; i >= 0; i--)
            if (!busy[i]) free_idx = IDX_W'(i);
    end

    assign count_out = cnt;
    assign disp_rdy  = (cnt < CNT_W'(DEPTH));
    assign disp_fire = rs.disp_valid_in && disp_rdy && rdy_in && !flush_in;

    always_comb begin
        cand = '0;
        for (int i = 0; i < DEPTH; i++)
            cand[i] = busy[i] && (e_qj[i] == '0) && (e_qk[i] == '0);
    end

    // Winner: a candidate that no other candidate is older than.
    always_comb begin
        win_idx = '0;
        win_vld = 1'b0;
        blocked = 1'b0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            blocked = 1'b0;
            for (int j = 0; j < DEPTH; j++)
                if (cand[j] && older[j][i]) blocked = 1'b1;
            if (cand[i] && !blocked) begin
                win_idx = IDX_W'(i);
                win_vld = 1'b1;
            end
        end
    end

    assign iss_load = rdy_in && !flush_in && win_vld && (!iss_vld_p1 || rs.issue_ready_in);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            wk_j[i] = cdb_lookup(e_qj[i], rs.cdb_valid_in, rs.cdb_tag_in, rs.cdb_data_in);
            wk_k[i] = cdb_lookup(e_qk[i], rs.cdb_valid_in, rs.cdb_tag_in, rs.cdb_data_in);
        end
        disp_qk_eff = rs.disp_use_k_in ? rs.disp_qk_in : '0;
        dj_hit = cdb_lookup(rs.disp_qj_in, rs.cdb_valid_in, rs.cdb_tag_in, rs.cdb_data_in);
        dk_hit = cdb_lookup(disp_qk_eff, rs.cdb_valid_in, rs.cdb_tag_in, rs.cdb_data_in);
    end

    // Stage p0: entry payload, wakeup capture and dispatch write (no reset, gated by busy).
    always_ff @(posedge clk_in) begin
        if (rdy_in && !flush_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (busy[i] && wk_j[i][DATA_W]) begin
                    e_qj[i] <= '0;
                    e_vj[i] <= wk_j[i][DATA_W-1:0];
                end
                if (busy[i] && wk_k[i][DATA_W]) begin
                    e_qk[i] <= '0;
                    e_vk[i] <= wk_k[i][DATA_W-1:0];
                end
            end
            if (disp_fire) begin
                e_a[free_idx]    <= rs.disp_a_in;
                e_qj[free_idx]   <= dj_hit[DATA_W] ? '0 : rs.disp_qj_in;
                e_vj[free_idx]   <= dj_hit[DATA_W] ? dj_hit[DATA_W-1:0] : rs.disp_vj_in;
                e_qk[free_idx]   <= dk_hit[DATA_W] ? '0 : disp_qk_eff;
                e_vk[free_idx]   <= dk_hit[DATA_W] ? dk_hit[DATA_W-1:0] : rs.disp_vk_in;
                e_dest[free_idx] <= rs.disp_dest_in;
                e_pc[free_idx]   <= rs.disp_pc_in;
                e_op[free_idx]   <= rs.disp_opcode_in;
            end
        end
    end

    // Stage p1: occupancy, age matrix and issue register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            busy        <= '0;
            for (int i = 0; i < DEPTH; i++) older[i] <= '0;
            iss_vld_p1  <= 1'b0;
            iss_a_p1    <= '0;
            iss_vj_p1   <= '0;
            iss_vk_p1   <= '0;
            iss_dest_p1 <= '0;
            iss_pc_p1   <= '0;
            iss_op_p1   <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                busy       <= '0;
                iss_vld_p1 <= 1'b0;
            end else begin
                if (iss_load) begin
                    busy[win_idx] <= 1'b0;
                    iss_vld_p1    <= 1'b1;
                    iss_a_p1      <= e_a[win_idx];
                    iss_vj_p1     <= e_vj[win_idx];
                    iss_vk_p1     <= e_vk[win_idx];
                    iss_dest_p1   <= e_dest[win_idx];
                    iss_pc_p1     <= e_pc[win_idx];
                    iss_op_p1     <= e_op[win_idx];
                end else if (rs.issue_ready_in) begin
                    iss_vld_p1 <= 1'b0;
                end
                if (disp_fire) begin
                    busy[free_idx]  <= 1'b1;
                    older[free_idx] <= '0;
                    for (int j = 0; j < DEPTH; j++)
                        older[j][free_idx] <= busy[j];
                end
            end
        end
    end

    assign rs.disp_ready_out   = disp_rdy;
    assign rs.issue_valid_out  = iss_vld_p1;
    assign rs.issue_a_out      = iss_a_p1;
    assign rs.issue_vj_out     = iss_vj_p1;
    assign rs.issue_vk_out     = iss_vk_p1;
    assign rs.issue_dest_out   = iss_dest_p1;
    assign rs.issue_pc_out     = iss_pc_p1;
    assign rs.issue_opcode_out = iss_op_p1;
endmodule

// File: tb/tb_alu_rs_gen.sv
// Bench for alu_rs_gen: directed stimulus with a scoreboard of expected issues.
module tb_alu_rs_gen;
    logic       clk, rst_n, rdy, flush;
    logic [3:0] count;
    int         n_checks = 0;
    int         n_errors = 0;

    typedef struct packed {
        logic [3:0]  dest;
        logic [31:0] vj;
        logic [31:0] vk;
        logic [31:0] a;
        logic [31:0] pc;
        logic [5:0]  op;
    } exp_t;
    exp_t exp_q[$];

    alu_rs_gen_if #(.DATA_W(32), .TAG_W(4), .ADDR_W(32), .OP_W(6), .CDB_N(2)) bus ();

    alu_rs_gen #(.DEPTH(8), .DATA_W(32), .TAG_W(4), .ADDR_W(32), .OP_W(6), .CDB_N(2)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy), .flush_in(flush),
        .rs(bus), .count_out(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pl_a(input logic [3:0] d);
        return 32'hA000_0000 | 32'(d);
    endfunction
    function automatic logic [31:0] pl_pc(input logic [3:0] d);
        return 32'h0000_1000 + 32'(d) * 4;
    endfunction
    function automatic logic [5:0] pl_op(input logic [3:0] d);
        return 6'h20 | 6'(d);
    endfunction

    task automatic disp(input logic [3:0] dest, input logic [3:0] qj, input logic [31:0] vj,
                        input logic [3:0] qk, input logic [31:0] vk, input logic use_k);
        bus.disp_valid_in  = 1'b1;
        bus.disp_dest_in   = dest;
        bus.disp_qj_in     = qj;
        bus.disp_vj_in     = vj;
        bus.disp_qk_in     = qk;
        bus.disp_vk_in     = vk;
        bus.disp_use_k_in  = use_k;
        bus.disp_a_in      = pl_a(dest);
        bus.disp_pc_in     = pl_pc(dest);
        bus.disp_opcode_in = pl_op(dest);
    endtask

    task automatic push(input logic [3:0] dest, input logic [31:0] vj, input logic [31:0] vk);
        exp_q.push_back('{dest: dest, vj: vj, vk: vk, a: pl_a(dest), pc: pl_pc(dest), op: pl_op(dest)});
    endtask

    task automatic cdb(input int port, input logic [3:0] tag, input logic [31:0] data);
        bus.cdb_valid_in[port]          = 1'b1;
        bus.cdb_tag_in[port*4 +: 4]     = tag;
        bus.cdb_data_in[port*32 +: 32]  = data;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        bus.disp_valid_in = 1'b0;
        bus.cdb_valid_in  = '0;
        flush             = 1'b0;
    endtask

    // Scoreboard: every accepted issue is compared with the oldest expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && rdy && !flush && bus.issue_valid_out && bus.issue_ready_in) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected", 64'(bus.issue_dest_out), 64'hFFFF);
            end else begin
                e = exp_q.pop_front();
                check("sb_dest", 64'(bus.issue_dest_out), 64'(e.dest));
                check("sb_vj", 64'(bus.issue_vj_out), 64'(e.vj));
                check("sb_vk", 64'(bus.issue_vk_out), 64'(e.vk));
                check("sb_a", 64'(bus.issue_a_out), 64'(e.a));
                check("sb_pc", 64'(bus.issue_pc_out), 64'(e.pc));
                check("sb_op", 64'(bus.issue_opcode_out), 64'(e.op));
            end
        end
    end

    initial begin
        rst_n = 1'b0; rdy = 1'b1; flush = 1'b0;
        bus.disp_valid_in = 1'b0; bus.disp_a_in = '0; bus.disp_qj_in = '0; bus.disp_qk_in = '0;
        bus.disp_vj_in = '0; bus.disp_vk_in = '0; bus.disp_dest_in = '0; bus.disp_pc_in = '0;
        bus.disp_opcode_in = '0; bus.disp_use_k_in = 1'b0;
        bus.cdb_valid_in = '0; bus.cdb_tag_in = '0; bus.cdb_data_in = '0;
        bus.issue_ready_in = 1'b1;
        #2;
        check("rst_valid", 64'(bus.issue_valid_out), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_ready", 64'(bus.disp_ready_out), 64'd1);
        check("rst_dest", 64'(bus.issue_dest_out), 64'd0);
        #10 rst_n = 1'b1;
        step();

        // Ordering and first-issue latency
        disp(4'd1, 4'd0, 32'h11, 4'd0, 32'h101, 1'b1); push(4'd1, 32'h11, 32'h101); step();
        check("ord_cnt1", 64'(count), 64'd1);
        disp(4'd2, 4'd0, 32'h22, 4'd0, 32'h202, 1'b1); push(4'd2, 32'h22, 32'h202); step();
        check("ord_lat_vld", 64'(bus.issue_valid_out), 64'd1);
        check("ord_d1", 64'(bus.issue_dest_out), 64'd1);
        disp(4'd3, 4'd0, 32'h33, 4'd0, 32'h303, 1'b1); push(4'd3, 32'h33, 32'h303); step();
        check("ord_d2", 64'(bus.issue_dest_out), 64'd2);
        step();
        check("ord_d3", 64'(bus.issue_dest_out), 64'd3);
        step();
        check("ord_drain_vld", 64'(bus.issue_valid_out), 64'd0);
        check("ord_drain_cnt", 64'(count), 64'd0);

        // Same-cycle capture on port 1; qk ignored when use_k is low
        disp(4'd5, 4'd4, 32'h0, 4'd9, 32'h77, 1'b0); cdb(1, 4'd4, 32'hDEAD);
        push(4'd5, 32'hDEAD, 32'h77); step();
        step(); step();

        // Lowest port wins on a duplicate tag
        disp(4'd6, 4'd7, 32'h0, 4'd0, 32'h66, 1'b1); push(4'd6, 32'hA, 32'h66); step();
        cdb(0, 4'd7, 32'hA); cdb(1, 4'd7, 32'hB); step();
        step(); step();

        // Wakeup on qk: woken entry is not selected in the same cycle
        disp(4'd7, 4'd0, 32'h70, 4'd3, 32'h0, 1'b1); push(4'd7, 32'h70, 32'h33); step();
        cdb(0, 4'd3, 32'h33); step();
        check("wake_not_same", 64'(bus.issue_valid_out), 64'd0);
        check("wake_cnt", 64'(count), 64'd1);
        step();
        check("wake_issue", 64'(bus.issue_dest_out), 64'd7);
        step(); step();

        // Back-pressure
        bus.issue_ready_in = 1'b0;
        disp(4'd10, 4'd0, 32'hA0, 4'd0, 32'hA1, 1'b1); push(4'd10, 32'hA0, 32'hA1); step();
        disp(4'd11, 4'd0, 32'hB0, 4'd0, 32'hB1, 1'b1); push(4'd11, 32'hB0, 32'hB1); step();
        for (int c = 0; c < 3; c++) begin
            check("bp_vld", 64'(bus.issue_valid_out), 64'd1);
            check("bp_dest", 64'(bus.issue_dest_out), 64'd10);
            check("bp_vj", 64'(bus.issue_vj_out), 64'hA0);
            check("bp_cnt", 64'(count), 64'd1);
            step();
        end
        bus.issue_ready_in = 1'b1;
        step();
        check("bp_next", 64'(bus.issue_dest_out), 64'd11);
        check("bp_next_vld", 64'(bus.issue_valid_out), 64'd1);
        step();
        check("bp_empty", 64'(bus.issue_valid_out), 64'd0);

        // Age beats index: fill all entries with pending operands
        for (int i = 0; i < 8; i++) begin
            disp(4'(i+1), 4'(i+1), 32'h0, 4'd0, 32'(i), 1'b1); step();
        end
        check("full_cnt", 64'(count), 64'd8);
        check("full_rdy", 64'(bus.disp_ready_out), 64'd0);
        cdb(0, 4'd1, 32'h100); push(4'd1, 32'h100, 32'd0); step();
        check("full_woken_rdy", 64'(bus.disp_ready_out), 64'd0);
        step();
        check("age_first", 64'(bus.issue_dest_out), 64'd1);
        check("age_cnt7", 64'(count), 64'd7);
        step();
        disp(4'd9, 4'd9, 32'h0, 4'd0, 32'h99, 1'b1); step();
        cdb(0, 4'd9, 32'h900); cdb(1, 4'd6, 32'h600);
        push(4'd6, 32'h600, 32'd5); push(4'd9, 32'h900, 32'h99); step();
        step();
        check("age_older", 64'(bus.issue_dest_out), 64'd6);
        step();
        check("age_younger", 64'(bus.issue_dest_out), 64'd9);
        step();

        // Full then flush with a dispatch attempt
        disp(4'd14, 4'd14, 32'h0, 4'd0, 32'h0, 1'b1); step();
        disp(4'd15, 4'd15, 32'h0, 4'd0, 32'h0, 1'b1); step();
        check("ff_rdy", 64'(bus.disp_ready_out), 64'd0);
        flush = 1'b1; disp(4'd13, 4'd0, 32'h13, 4'd0, 32'h0, 1'b1); cdb(0, 4'd2, 32'h2); step();
        check("ff_cnt", 64'(count), 64'd0);
        check("ff_vld", 64'(bus.issue_valid_out), 64'd0);

        // Flush while not full: the dispatch must be discarded
        disp(4'd12, 4'd3, 32'h0, 4'd0, 32'h0, 1'b1); step();
        flush = 1'b1; disp(4'd13, 4'd0, 32'h13, 4'd0, 32'h0, 1'b1); step();
        check("fl_cnt", 64'(count), 64'd0);
        step();
        check("fl_nowrite", 64'(bus.issue_valid_out), 64'd0);

        // Pause ignores dispatch and flush
        bus.issue_ready_in = 1'b0;
        disp(4'd12, 4'd0, 32'hC0, 4'd0, 32'hC1, 1'b1); push(4'd12, 32'hC0, 32'hC1); step();
        step();
        rdy = 1'b0;
        for (int c = 0; c < 2; c++) begin
            flush = 1'b1; disp(4'd13, 4'd0, 32'h13, 4'd0, 32'h0, 1'b1); step();
            check("pause_vld", 64'(bus.issue_valid_out), 64'd1);
            check("pause_dest", 64'(bus.issue_dest_out), 64'd12);
            check("pause_cnt", 64'(count), 64'd0);
        end
        rdy = 1'b1; bus.issue_ready_in = 1'b1; step();
        check("pause_done", 64'(bus.issue_valid_out), 64'd0);

        // Asynchronous reset mid-cycle
        bus.issue_ready_in = 1'b0;
        disp(4'd1, 4'd0, 32'h1, 4'd0, 32'h1, 1'b1); step();
        disp(4'd2, 4'd0, 32'h2, 4'd0, 32'h2, 1'b1); step();
        check("ar_pre_vld", 64'(bus.issue_valid_out), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_vld", 64'(bus.issue_valid_out), 64'd0);
        check("ar_cnt", 64'(count), 64'd0);
        check("ar_dest", 64'(bus.issue_dest_out), 64'd0);
        check("ar_rdy", 64'(bus.disp_ready_out), 64'd1);
        #1 rst_n = 1'b1;
        bus.issue_ready_in = 1'b1;
        step(); step();

        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
